// File: rtl/mips16_trace_pkg.sv
// Shared types and entry layout for the mips16 trace buffer.
package mips16_trace_pkg;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_ARMED   = 2'd1,
    TR_CAPTURE = 2'd2,
    TR_DONE    = 2'd3
  } tr_state_e;

  localparam int TRACE_W    = 32;
  localparam int TR_PC_LSB  = 16;
  localparam int TR_ALU_LSB = 0;

  function automatic logic [TRACE_W-1:0] pack_entry(input logic [15:0] pc,
                                                    input logic [15:0] alu);
    logic [TRACE_W-1:0] e;
    e = '0;
    e[TR_PC_LSB +: 16]  = pc;
    e[TR_ALU_LSB +: 16] = alu;
    return e;
  endfunction

endpackage

// File: rtl/mips16_trace_fifo.sv
// First-word-fall-through FIFO; a push is accepted when full if a pop happens in the same cycle.
module mips16_trace_fifo #(
  parameter  int DEPTH = 16,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == FULL_LVL);
  assign level_o = level_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Gated to zero when empty so the head reads as 0 straight out of reset.
  assign data_o = empty_o ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/mips16_trace_buffer.sv
// Triggered PC/ALU trace capture into a drainable FIFO.
// Optional TRACE_DEDUP_EN suppresses repeated-PC samples during capture.
module mips16_trace_buffer
  import mips16_trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int CAPTURE_LEN = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              pc_in,
  input  logic [15:0]              alu_in,
  input  logic                     arm,
  input  logic [15:0]              trig_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TRACE_W-1:0]       out_data,
  output logic [1:0]               state_o,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam logic [15:0] LEN16 = 16'(CAPTURE_LEN);

  tr_state_e   state_q;
  logic [15:0] cnt_q, cnt_d;
  logic        overflow_q;
  logic        trig_hit, in_cap, sample, dup, push, pop;
  logic        fifo_full, fifo_empty;

  assign trig_hit = (state_q == TR_ARMED) && (pc_in == trig_pc);
  assign in_cap   = (state_q == TR_CAPTURE);
  assign sample   = trig_hit || in_cap;
  assign cnt_d    = cnt_q + 16'd1;

`ifdef TRACE_DEDUP_EN
  logic [15:0] prev_pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_pc_q <= '0;
    else        prev_pc_q <= pc_in;
  end

  // The trigger-cycle sample is never deduplicated.
  assign dup = in_cap && (pc_in == prev_pc_q);
`else
  assign dup = 1'b0;
`endif

  assign push      = sample && !dup;
  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign state_o   = state_q;
  assign overflow  = overflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TR_IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        TR_IDLE: if (arm) begin
          state_q    <= TR_ARMED;
          overflow_q <= 1'b0;
        end
        TR_ARMED: if (trig_hit) begin
          cnt_q   <= 16'd1;
          state_q <= (LEN16 == 16'd1) ? TR_DONE : TR_CAPTURE;
        end
        TR_CAPTURE: begin
          cnt_q <= cnt_d;
          if (cnt_d == LEN16) state_q <= TR_DONE;
        end
        TR_DONE: if (arm && fifo_empty) begin
          state_q    <= TR_ARMED;
          overflow_q <= 1'b0;
        end
        default: state_q <= TR_IDLE;
      endcase
      // Dropped samples still advance the window counter above.
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  mips16_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (TRACE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pack_entry(pc_in, alu_in)),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

endmodule

// File: doc/mips16_trace_buffer.md
# mips16_trace_buffer

Downstream observation stage for the `mips_16` core. It samples the core's `pc_out` and `alu_result` every cycle once a PC trigger fires, and buffers a fixed-length window of `{pc, alu}` entries in a FIFO. The entries drain over a valid/ready stream to a debug host. The block is passive: it never back-pressures or stalls the core, and it drops samples when its FIFO is full.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `CAPTURE_LEN`, 32: sampled cycles per capture window; 1..65535.

- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low; asserting it (0) clears all state immediately.
- `pc_in` in 16: from core `pc_out`.
- `alu_in` in 16: from core `alu_result`.
- `arm` in 1: single-cycle request to arm the trigger.
- `trig_pc` in 16: trigger PC; sampled every cycle while ARMED.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: consumer accepts `out_data` when high with `out_valid`.
- `out_data` out 32: head entry, `{pc[15:0], alu[15:0]}`.
- `state_o` out 2: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- `overflow` out 1: sticky; a sample was dropped because the FIFO was full.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **IDLE**
  - `arm` → ARMED.
- **ARMED**
  - `pc_in == trig_pc` → CAPTURE. The trigger cycle's sample is written.
  - `arm` while ARMED is ignored.
- **CAPTURE**
  - One sample per cycle. A 16-bit window counter starts at 1 on the trigger cycle.
  - After the CAPTURE_LEN-th sample → DONE. CAPTURE_LEN=1 goes straight from ARMED to DONE.
- **DONE**
  - `arm` → ARMED, but only if `level == 0`; otherwise `arm` is ignored.
  - `arm` clears `overflow` when it is accepted.
- **Writes**
  - Accepted if `level < DEPTH`, or if a pop happens in the same cycle.
  - A sample that is not accepted is dropped. `overflow` ← 1, and the sample still counts toward CAPTURE_LEN.
- **Pops**
  - A pop occurs on `out_valid && out_ready`.
  - The FIFO is first-word-fall-through: `out_data` is the head whenever `out_valid` is high; it is undefined otherwise.
  - Simultaneous push and pop leaves `level` unchanged.
- **Pointers**
  - $clog2(DEPTH) bits each, wrapping modulo DEPTH.
  - `level` is kept separately, in the range 0..DEPTH.
- **Drain**
  - Draining continues in every state, including IDLE and DONE.

## Timing
- **Reset values**
  - State IDLE.
  - `out_valid`=0, `level`=0, `overflow`=0, `state_o`=0, `out_data`=0.
  - Pointers and window counter 0.
- **Write latency**: a sample taken at edge N gives `out_valid`=1 and updated `level` after edge N. No combinational path exists from `pc_in` to the outputs.
- **Trigger compare**: combinational on the current `pc_in`/`trig_pc`; `state_o` becomes CAPTURE after that edge.
- **`out_ready`**: may toggle freely. `out_data` stays stable while `out_valid && !out_ready`.
- **Reset mid-capture**: FIFO contents are discarded and the state returns to IDLE asynchronously. Outputs return to their reset values without waiting for `clk`.

## Configuration
- **`TRACE_DEDUP_EN`**
  - In CAPTURE, a sample whose `pc_in` equals the previous cycle's `pc_in` is neither written nor counted as overflow. This suppresses stalls and self-loops.
  - The trigger-cycle sample is always written.
  - Dedup-suppressed samples still count toward CAPTURE_LEN, so the window stays cycle-based.
- **Without the macro**: every CAPTURE cycle is a write attempt. The previous-PC register is not instantiated.

## Structure
- **Package `mips16_trace_pkg`**
  - State enum: `TR_IDLE`, `TR_ARMED`, `TR_CAPTURE`, `TR_DONE`.
  - `TRACE_W` = 32.
  - Field offsets `TR_PC_LSB` = 16, `TR_ALU_LSB` = 0.
- **Sub-module `mips16_trace_fifo`**
  - Parameterised FWFT FIFO with push, pop, full, empty and level.
  - The top level holds the FSM, window counter, overflow flag and dedup logic.

## Test plan
- **Basic capture**: DEPTH=16, CAPTURE_LEN=4, `trig_pc`=0x0010; `arm`, then `pc_in` sequence 0x000E, 0x0010, 0x0012, 0x0014, 0x0016 with `out_ready`=1.
  - Required: four entries 0x0010xxxx..0x0016xxxx, then DONE and `overflow`=0.
- **Overflow**: DEPTH=4, CAPTURE_LEN=8, `out_ready`=0.
  - Required: `level` saturates at 4, `overflow`=1, the first four PCs are retained, then DONE.
- **Arm rules**: `arm` in DONE with `level`=2 is ignored. Drain to 0, then `arm` → ARMED and `overflow` cleared.
- **Push/pop at full**: `level`=DEPTH, push and pop in the same cycle.
  - Required: `level` stays DEPTH and `overflow` stays 0.
- **Reset mid-capture**: drop `reset` to 0 mid-CAPTURE with 3 entries queued.
  - Required, immediately: `out_valid`=0, `level`=0, `state_o`=0.
- **Dedup**: with `TRACE_DEDUP_EN`, `pc_in` 0x0010, 0x0010, 0x0010, 0x0012 and CAPTURE_LEN=4.
  - Required: exactly 2 entries (0x0010, 0x0012).
  - Without the macro: 4 entries.
